// File: rtl/swap_request_scheduler_pkg.sv
// Shared types and defaults for the swap request scheduler.
// Queued swap addresses are carried as swap_req_t, so AW must not exceed DEFAULT_AW.
package swap_request_scheduler_pkg;

   localparam int unsigned DEFAULT_AW = 8;
   localparam int unsigned DEFAULT_DW = 8;

   typedef enum logic {
      IDLE,
      SWAP
   } state_t;

   typedef enum logic {
      GRANT_WRITE,
      GRANT_SWAP
   } grant_t;

   typedef struct packed {
      logic [DEFAULT_AW-1:0] a;
      logic [DEFAULT_AW-1:0] b;
   } swap_req_t;

endpackage

// File: rtl/swap_req_fifo.sv
// Synchronous FIFO for pending swap requests; power-of-2 depth, head visible on dout.
module swap_req_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   // Head read straight from storage: an entry pushed this cycle is not poppable until the next.
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/swap_request_scheduler.sv
// Turns host write and swap requests into swap register file controls,
// alternating writes and queued swaps and holding rf_swap for SWAP_CYCLES cycles.
module swap_request_scheduler
   import swap_request_scheduler_pkg::*;
#(
   parameter int unsigned AW          = DEFAULT_AW,
   parameter int unsigned DW          = DEFAULT_DW,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SWAP_CYCLES = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [AW-1:0]            wr_addr,
   input  logic [DW-1:0]            wr_data,
   input  logic                     sw_valid,
   output logic                     sw_ready,
   input  logic [AW-1:0]            sw_addr_a,
   input  logic [AW-1:0]            sw_addr_b,
   output logic                     rf_we,
   output logic [AW-1:0]            rf_address_w,
   output logic [DW-1:0]            rf_data_w,
   output logic                     rf_swap,
   output logic [AW-1:0]            rf_address_A,
   output logic [AW-1:0]            rf_address_B,
   output logic                     swap_done,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int unsigned      CNT_W    = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SWAP_CYCLES - 1);

   state_t           state;
   grant_t           last_grant;
   logic [CNT_W-1:0] cnt;
   swap_req_t        req_in;
   swap_req_t        head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic             write_grant;
   logic             swap_grant;

   always_comb begin
      req_in.a = DEFAULT_AW'(sw_addr_a);
      req_in.b = DEFAULT_AW'(sw_addr_b);
   end

   assign sw_ready = ~fifo_full;
   assign push     = sw_valid & sw_ready;

   // A write is held off only when it was granted last and a swap is waiting, so both make progress.
   assign wr_ready    = (state == IDLE) & ~(~fifo_empty & (last_grant == GRANT_WRITE));
   assign write_grant = wr_valid & wr_ready;
   assign swap_grant  = (state == IDLE) & ~fifo_empty & (~wr_valid | (last_grant == GRANT_WRITE));
   assign pop         = swap_grant;

   assign busy = (state != IDLE) | ~fifo_empty;

   swap_req_fifo #(
      .WIDTH ($bits(swap_req_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (req_in),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         last_grant   <= GRANT_SWAP;
         cnt          <= '0;
         rf_we        <= 1'b0;
         rf_address_w <= '0;
         rf_data_w    <= '0;
         rf_swap      <= 1'b0;
         rf_address_A <= '0;
         rf_address_B <= '0;
         swap_done    <= 1'b0;
      end else begin
         rf_we     <= 1'b0;
         swap_done <= 1'b0;
         case (state)
            IDLE: begin
               if (write_grant) begin
                  rf_we        <= 1'b1;
                  rf_address_w <= wr_addr;
                  rf_data_w    <= wr_data;
                  last_grant   <= GRANT_WRITE;
               end else if (swap_grant) begin
                  last_grant <= GRANT_SWAP;
                  // Swapping a register with itself is a no-op: retire without touching the file.
                  if (head.a == head.b) begin
                     swap_done <= 1'b1;
                  end else begin
                     rf_swap      <= 1'b1;
                     rf_address_A <= AW'(head.a);
                     rf_address_B <= AW'(head.b);
                     cnt          <= CNT_LOAD;
                     state        <= SWAP;
                  end
               end
            end
            SWAP: begin
               if (cnt == '0) begin
                  rf_swap   <= 1'b0;
                  swap_done <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
